// File: rtl/gather2d_engine.sv
// Block-structured 2D gather: index RAM lookup, lane-parallel source read,
// pipelined multi-channel scratchpad write.
module gather2d_engine #(
  parameter int DATA_W = 32,
  parameter int IDX_W  = 16,
  parameter int D_W    = 16,
  parameter int ADDR_W = 16,
  parameter int NUM_CH = 2
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     start,
  input  logic                     abort,
  input  logic [IDX_W-1:0]         s_tokens,
  input  logic [D_W-1:0]           head_dim_d,
  input  logic [IDX_W-1:0]         num_blocks,
  input  logic [NUM_CH-1:0]        ch_en,
  output logic [IDX_W-1:0]         idx_rd_addr,
  input  logic [IDX_W-1:0]         idx_rd_data,
  output logic                     src_rd_en,
  output logic [ADDR_W-1:0]        src_rd_addr,
  input  logic [NUM_CH*DATA_W-1:0] src_rd_data,
  output logic [NUM_CH-1:0]        wr_en,
  output logic [ADDR_W-1:0]        wr_addr,
  output logic [NUM_CH*DATA_W-1:0] wr_data,
  output logic                     busy,
  output logic                     done,
  output logic                     err_oob
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_IDX,
    S_LATCH,
    S_STREAM,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t state_q, state_d;

  logic [IDX_W-1:0]  tok_q;
  logic [IDX_W-1:0]  nblk_q;
  logic [IDX_W-1:0]  tok_cnt;
  logic [IDX_W-1:0]  idx_q;
  logic [D_W-1:0]    dim_q;
  logic [D_W-1:0]    d_cnt;
  logic [NUM_CH-1:0] ch_en_q;
  logic              oob_q;
  logic              err_q;
  logic              wr_valid_q;
  logic              wr_oob_q;
  logic [ADDR_W-1:0] wr_addr_q;

  logic              zero_cfg;
  logic              last_d;
  logic              more_tok;
  logic              idx_oob;
  logic              kill;
  logic [ADDR_W-1:0] src_addr;
  logic [ADDR_W-1:0] dst_addr;

  assign zero_cfg = (s_tokens == '0) || (head_dim_d == '0);
  assign last_d   = d_cnt == (dim_q - D_W'(1));
  assign more_tok = ({1'b0, tok_cnt} + (IDX_W+1)'(1))
                    < {1'b0, tok_q};
  assign idx_oob  = idx_rd_data >= nblk_q;
  assign busy     = (state_q == S_IDX) || (state_q == S_LATCH)
                 || (state_q == S_STREAM) || (state_q == S_DRAIN);
  assign kill     = abort && busy;

  // Mod-2^ADDR_W arithmetic gives the truncated full-width result.
  assign src_addr = ADDR_W'(idx_q) * ADDR_W'(dim_q)
                  + ADDR_W'(d_cnt);
  assign dst_addr = ADDR_W'(tok_cnt) * ADDR_W'(dim_q)
                  + ADDR_W'(d_cnt);

  assign idx_rd_addr = tok_cnt;
  assign src_rd_en   = (state_q == S_STREAM) && !oob_q;
  assign src_rd_addr = (state_q == S_STREAM) ? src_addr : '0;
  assign wr_en       = {NUM_CH{wr_valid_q}} & ch_en_q;
  assign wr_addr     = wr_addr_q;
  assign wr_data     = (wr_valid_q && !wr_oob_q) ? src_rd_data : '0;
  assign done        = state_q == S_DONE;
  assign err_oob     = err_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) state_d = zero_cfg ? S_DONE : S_IDX;
      end
      S_IDX:   state_d = S_LATCH;
      S_LATCH: state_d = S_STREAM;
      S_STREAM: begin
        if (last_d) state_d = more_tok ? S_IDX : S_DRAIN;
      end
      S_DRAIN: state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (kill) state_d = S_IDLE;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      tok_q      <= '0;
      nblk_q     <= '0;
      tok_cnt    <= '0;
      idx_q      <= '0;
      dim_q      <= '0;
      d_cnt      <= '0;
      ch_en_q    <= '0;
      oob_q      <= 1'b0;
      err_q      <= 1'b0;
      wr_valid_q <= 1'b0;
      wr_oob_q   <= 1'b0;
      wr_addr_q  <= '0;
    end else begin
      wr_valid_q <= 1'b0;
      if (!kill) begin
        unique case (state_q)
          S_IDLE: begin
            if (start) begin
              tok_q   <= s_tokens;
              dim_q   <= head_dim_d;
              nblk_q  <= num_blocks;
              ch_en_q <= ch_en;
              tok_cnt <= '0;
              d_cnt   <= '0;
              if (!zero_cfg) err_q <= 1'b0;
            end
          end
          S_LATCH: begin
            idx_q <= idx_rd_data;
            oob_q <= idx_oob;
            if (idx_oob) err_q <= 1'b1;
          end
          S_STREAM: begin
            wr_valid_q <= 1'b1;
            wr_addr_q  <= dst_addr;
            wr_oob_q   <= oob_q;
            if (last_d) begin
              d_cnt <= '0;
              if (more_tok) tok_cnt <= tok_cnt + IDX_W'(1);
            end else begin
              d_cnt <= d_cnt + D_W'(1);
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_gather2d_engine.sv
// Bench for gather2d_engine: table vectors, random runs and reset/abort
// sequences checked cycle by cycle against a per-cycle schedule model.
module tb_gather2d_engine;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [15:0] s_tokens = '0;
  logic [15:0] head_dim_d = '0;
  logic [15:0] num_blocks = '0;
  logic [1:0]  ch_en = '0;
  logic [15:0] idx_rd_addr;
  logic [15:0] idx_rd_data = '0;
  logic        src_rd_en;
  logic [15:0] src_rd_addr;
  logic [63:0] src_rd_data = '0;
  logic [1:0]  wr_en;
  logic [15:0] wr_addr;
  logic [63:0] wr_data;
  logic        busy;
  logic        done;
  logic        err_oob;

  int n_chk = 0;
  int n_fail = 0;
  logic err_m = 1'b0;
  logic [15:0] idx_mem [64];

  gather2d_engine #(
    .DATA_W(32), .IDX_W(16), .D_W(16), .ADDR_W(16), .NUM_CH(2)
  ) dut (
    .clk(clk), .rstn(rstn), .start(start), .abort(abort),
    .s_tokens(s_tokens), .head_dim_d(head_dim_d),
    .num_blocks(num_blocks), .ch_en(ch_en),
    .idx_rd_addr(idx_rd_addr), .idx_rd_data(idx_rd_data),
    .src_rd_en(src_rd_en), .src_rd_addr(src_rd_addr),
    .src_rd_data(src_rd_data), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .busy(busy), .done(done), .err_oob(err_oob)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] lane(logic [15:0] a, int c);
    return (32'(c + 1) << 28) ^ (32'(a) * 32'h9E37) ^ 32'h0000_A5A5;
  endfunction

  always @(posedge clk) begin
    idx_rd_data <= idx_mem[idx_rd_addr[5:0]];
    if (src_rd_en)
      src_rd_data <= {lane(src_rd_addr, 1), lane(src_rd_addr, 0)};
    else
      src_rd_data <= {$urandom, $urandom};
  end

  task automatic chk(string nm, int k, logic [63:0] act,
                     logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cyc %0d: got %h expected %h", nm, k, act, exp);
    end
  endtask

  task automatic chk_all_zero(string nm);
    chk({nm, "_busy"}, 0, 64'(busy), 64'd0);
    chk({nm, "_done"}, 0, 64'(done), 64'd0);
    chk({nm, "_err"}, 0, 64'(err_oob), 64'd0);
    chk({nm, "_wr_en"}, 0, 64'(wr_en), 64'd0);
    chk({nm, "_src_en"}, 0, 64'(src_rd_en), 64'd0);
    chk({nm, "_addrs"}, 0,
        {16'd0, idx_rd_addr, src_rd_addr, wr_addr}, 64'd0);
    chk({nm, "_wr_data"}, 0, wr_data, 64'd0);
  endtask

  // Schedule: token t occupies cycles t*(D+2)+1 .. ; IDX, LATCH, D x STREAM.
  task automatic run_op(input int T, input int D, input int nb,
                        input logic [1:0] ce, input int ka,
                        output int dcyc);
    int P, E, K, j, t, p, lim;
    logic zero, after;
    logic [15:0] idxv [8];
    logic oob [8];
    logic eb, ed, ee, esen, iscan, wrc;
    logic [15:0] esa, ewa, sa;
    logic [1:0] ewe;
    logic [63:0] ewd;
    zero = (T == 0) || (D == 0);
    P = D + 2;
    E = T * P;
    for (int i = 0; i < 8; i++) begin
      idxv[i] = idx_mem[i];
      oob[i] = (i < T) && (int'(idx_mem[i]) >= nb);
    end
    K = zero ? 3 : (ka > 0 ? ka + 4 : E + 3);
    dcyc = 0;
    @(posedge clk); #1;
    start = 1'b1; abort = 1'b0;
    s_tokens = 16'(T); head_dim_d = 16'(D);
    num_blocks = 16'(nb); ch_en = ce;
    for (int k = 1; k <= K; k++) begin
      @(posedge clk); #1;
      start = 1'b0;
      s_tokens = 16'($urandom); head_dim_d = 16'($urandom);
      num_blocks = 16'($urandom); ch_en = 2'($urandom);
      abort = (k == ka);
      @(negedge clk);
      eb = 0; ed = 0; esen = 0; iscan = 0; wrc = 0;
      esa = '0; ewa = '0; ewe = '0; ewd = '0; t = 0;
      after = (ka > 0) && (k > ka);
      if (zero) begin
        ed = (k == 1);
        ee = err_m;
      end else begin
        lim = after ? ka : k;
        ee = 1'b0;
        for (int i = 0; i < T; i++)
          if (oob[i] && (i * P + 2 < lim)) ee = 1'b1;
        if (!after) begin
          eb = (k >= 1) && (k <= E + 1);
          ed = (k == E + 2);
          j = k - 1;
          if (j >= 0 && j < E) begin
            t = j / P; p = j % P;
            if (p == 0) iscan = 1'b1;
            if (p >= 2) begin
              esen = !oob[t];
              esa = 16'(int'(idxv[t]) * D + p - 2);
            end
          end
          j = k - 2;
          if (j >= 0 && j < E && (j % P) >= 2) begin
            wrc = 1'b1;
            ewe = ce;
            ewa = 16'((j / P) * D + (j % P) - 2);
            sa = 16'(int'(idxv[j / P]) * D + (j % P) - 2);
            ewd = oob[j / P] ? 64'd0 : {lane(sa, 1), lane(sa, 0)};
          end
        end
      end
      if (done && dcyc == 0) dcyc = k;
      chk("busy", k, 64'(busy), 64'(eb));
      chk("done", k, 64'(done), 64'(ed));
      chk("err_oob", k, 64'(err_oob), 64'(ee));
      chk("src_rd_en", k, 64'(src_rd_en), 64'(esen));
      if (esen) chk("src_rd_addr", k, 64'(src_rd_addr), 64'(esa));
      if (iscan) chk("idx_rd_addr", k, 64'(idx_rd_addr), 64'(t));
      chk("wr_en", k, 64'(wr_en), 64'(ewe));
      if (wrc) begin
        chk("wr_addr", k, 64'(wr_addr), 64'(ewa));
        chk("wr_data", k, wr_data, ewd);
      end
      err_m = ee;
    end
    abort = 1'b0;
  endtask

  typedef struct {
    int          T;
    int          D;
    int          nb;
    logic [1:0]  ce;
    logic [15:0] i0;
    logic [15:0] i1;
    int          ka;
    int          exp_done;
  } vec_t;

  vec_t tbl [11];

  initial begin
    int dc, T, D, nb, E, ka;
    logic [1:0] ce;
    tbl[0]  = '{2, 4, 8, 2'b11, 16'd5, 16'd3, 0, 14};
    tbl[1]  = '{0, 4, 8, 2'b11, 16'd5, 16'd3, 0, 1};
    tbl[2]  = '{2, 0, 8, 2'b11, 16'd5, 16'd3, 0, 1};
    tbl[3]  = '{2, 2, 8, 2'b11, 16'd9, 16'd2, 0, 10};
    tbl[4]  = '{0, 4, 8, 2'b11, 16'd5, 16'd3, 0, 1};
    tbl[5]  = '{2, 4, 8, 2'b11, 16'd5, 16'd3, 0, 14};
    tbl[6]  = '{2, 4, 8, 2'b11, 16'd5, 16'd3, 4, 0};
    tbl[7]  = '{2, 4, 8, 2'b11, 16'd5, 16'd3, 0, 14};
    tbl[8]  = '{2, 4, 8, 2'b10, 16'd5, 16'd3, 0, 14};
    tbl[9]  = '{1, 32, 65535, 2'b11, 16'h1000, 16'd0, 0, 36};
    tbl[10] = '{2, 2, 8, 2'b11, 16'd9, 16'd2, 2, 0};
    for (int i = 0; i < 64; i++) idx_mem[i] = '0;

    #2;
    chk_all_zero("reset");
    @(negedge clk); rstn = 1'b1;

    for (int v = 0; v < 11; v++) begin
      idx_mem[0] = tbl[v].i0;
      idx_mem[1] = tbl[v].i1;
      run_op(tbl[v].T, tbl[v].D, tbl[v].nb, tbl[v].ce, tbl[v].ka, dc);
      chk("done_cycle", v, 64'(dc), 64'(tbl[v].exp_done));
    end

    for (int r = 0; r < 25; r++) begin
      T = $urandom_range(1, 5);
      D = $urandom_range(1, 6);
      nb = $urandom_range(1, 12);
      ce = 2'($urandom);
      for (int i = 0; i < 8; i++) idx_mem[i] = 16'($urandom_range(0, 15));
      E = T * (D + 2);
      ka = ($urandom_range(0, 3) == 0) ? $urandom_range(1, E + 1) : 0;
      run_op(T, D, nb, ce, ka, dc);
      chk("rand_done_cycle", r, 64'(dc), 64'(ka > 0 ? 0 : E + 2));
    end

    idx_mem[0] = 16'd5;
    idx_mem[1] = 16'd3;
    @(posedge clk); #1;
    start = 1'b1; s_tokens = 16'd2; head_dim_d = 16'd4;
    num_blocks = 16'd8; ch_en = 2'b11;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #2;
    chk("mid_stream_busy", 5, 64'(busy), 64'd1);
    chk("mid_stream_src_en", 5, 64'(src_rd_en), 64'd1);
    #1 rstn = 1'b0;
    #1;
    chk_all_zero("async_reset");
    @(negedge clk); rstn = 1'b1;
    err_m = 1'b0;
    run_op(2, 4, 8, 2'b11, 0, dc);
    chk("post_reset_done_cycle", 0, 64'(dc), 64'd14);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
